// File: rtl/corr_mac_seq.sv
// corr_mac_seq: sample-strobed, time-multiplexed correlator with one MAC.
//
// Each accepted sample shifts into an N-deep delay line, then N MAC
// cycles accumulate x[k]*coef[k]. In a DONE cycle the sum is published
// with a one-cycle corr_valid pulse and a |corr| > thresh detect flag.
//
// Optional feature macro: CORR_COEF_LOAD_EN
//   defined   - coefficient table is a register array, writable through
//               coef_we/coef_addr/coef_data while idle, reset to the
//               built-in sine table.
//   undefined - coefficients are the constant built-in table; the write
//               port is ignored.
module corr_mac_seq #(
  parameter int W     = 8,
  parameter int C     = 8,
  parameter int N     = 20,
  parameter int ACC_W = 25
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ena,
  input  logic                   sample_stb,
  input  logic [W-1:0]           rec,
  input  logic [ACC_W-2:0]       thresh,
  input  logic                   coef_we,
  input  logic [$clog2(N)-1:0]   coef_addr,
  input  logic [C-1:0]           coef_data,
  output logic [ACC_W-1:0]       corr,
  output logic                   corr_valid,
  output logic                   detect,
  output logic                   busy,
  output logic                   overrun
);

  localparam int AW = $clog2(N);
  localparam int PW = W + C;
  localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_reg, state_next;

  // Control strobes decoded from the current state.
  logic accept;     // strobe taken: shift delay line, start a new sum
  logic mac_en;     // one MAC step this cycle
  logic publish;    // DONE: move the sum to the outputs
  logic drop;       // strobe arrived while busy

  logic [AW-1:0]           idx_reg;
  logic signed [ACC_W-1:0] acc_reg;
  logic signed [W-1:0]     x_reg [N];

  logic [ACC_W-1:0] corr_reg;
  logic             corr_valid_reg;
  logic             detect_reg;
  logic             overrun_reg;

  logic signed [W-1:0]     x_cur;
  logic signed [C-1:0]     coef_cur;
  logic signed [PW-1:0]    prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0]        acc_mag;
  logic                    detect_next;

  // Built-in table: one period of a 20-point sine, amplitude 127.
  function automatic logic signed [C-1:0] base_coef(input int k);
    logic signed [7:0] s;
    case (k % 20)
      0:       s = 8'sd0;
      1:       s = 8'sd39;
      2:       s = 8'sd75;
      3:       s = 8'sd103;
      4:       s = 8'sd121;
      5:       s = 8'sd127;
      6:       s = 8'sd121;
      7:       s = 8'sd103;
      8:       s = 8'sd75;
      9:       s = 8'sd39;
      10:      s = 8'sd0;
      11:      s = -8'sd39;
      12:      s = -8'sd75;
      13:      s = -8'sd103;
      14:      s = -8'sd121;
      15:      s = -8'sd127;
      16:      s = -8'sd121;
      17:      s = -8'sd103;
      18:      s = -8'sd75;
      19:      s = -8'sd39;
      default: s = 8'sd0;
    endcase
    return C'(s);
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and control decode; everything holds while ena is low.
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    mac_en     = 1'b0;
    publish    = 1'b0;
    drop       = 1'b0;
    if (ena) begin
      case (state_reg)
        IDLE: begin
          if (sample_stb) begin
            accept     = 1'b1;
            state_next = MAC;
          end
        end
        MAC: begin
          mac_en = 1'b1;
          drop   = sample_stb;
          if (idx_reg == LAST_IDX) begin
            state_next = DONE;
          end
        end
        DONE: begin
          publish    = 1'b1;
          drop       = sample_stb;
          state_next = IDLE;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // Delay line: tap 0 takes the new sample, others take their neighbour.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_tap
      if (gi == 0) begin : g_head
        // Newest sample enters here on an accepted strobe.
        always_ff @(posedge clk) begin
          if (rst) begin
            x_reg[gi] <= '0;
          end else if (accept) begin
            x_reg[gi] <= rec;
          end
        end
      end else begin : g_body
        // Older taps shift one place on an accepted strobe.
        always_ff @(posedge clk) begin
          if (rst) begin
            x_reg[gi] <= '0;
          end else if (accept) begin
            x_reg[gi] <= x_reg[gi-1];
          end
        end
      end
    end
  endgenerate

`ifdef CORR_COEF_LOAD_EN
  logic signed [C-1:0] coef_reg [N];
  logic                coef_wr;

  // Writes land only while idle and enabled, and only for in-range taps.
  assign coef_wr = coef_we && ena && (state_reg == IDLE) &&
                   ({1'b0, coef_addr} < (AW+1)'(N));

  generate
    for (gi = 0; gi < N; gi++) begin : g_coef
      // Per-tap coefficient register, reset to the built-in table.
      always_ff @(posedge clk) begin
        if (rst) begin
          coef_reg[gi] <= base_coef(gi);
        end else if (coef_wr && (coef_addr == AW'(gi))) begin
          coef_reg[gi] <= coef_data;
        end
      end
    end
  endgenerate

  assign coef_cur = coef_reg[idx_reg];
`else
  logic unused_coef_port;

  // Write port has no effect in the fixed-table build.
  assign unused_coef_port = ^{coef_we, coef_addr, coef_data};
  assign coef_cur         = base_coef(int'(idx_reg));
`endif

  // Single multiplier, full precision, sign-extended into the accumulator.
  assign x_cur    = x_reg[idx_reg];
  assign prod     = x_cur * coef_cur;
  assign prod_ext = {{(ACC_W-PW){prod[PW-1]}}, prod};

  // Magnitude as an unsigned ACC_W value so the most negative sum
  // maps to 2^(ACC_W-1) instead of wrapping.
  assign acc_mag     = acc_reg[ACC_W-1] ? $unsigned(-acc_reg) : $unsigned(acc_reg);
  assign detect_next = acc_mag > {1'b0, thresh};

  // Accumulator and tap index: cleared on accept, advanced per MAC step.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg <= '0;
      idx_reg <= '0;
    end else if (accept) begin
      acc_reg <= '0;
      idx_reg <= '0;
    end else if (mac_en) begin
      acc_reg <= acc_reg + prod_ext;
      idx_reg <= (idx_reg == LAST_IDX) ? '0 : idx_reg + AW'(1);
    end
  end

  // Result registers, valid pulse and sticky overrun flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      corr_reg       <= '0;
      corr_valid_reg <= 1'b0;
      detect_reg     <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      corr_valid_reg <= publish;
      if (publish) begin
        corr_reg   <= acc_reg;
        detect_reg <= detect_next;
      end
      if (drop) begin
        overrun_reg <= 1'b1;
      end
    end
  end

  assign corr       = corr_reg;
  assign corr_valid = corr_valid_reg;
  assign detect     = detect_reg;
  assign overrun    = overrun_reg;
  assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_corr_mac_seq.sv
// Randomised self-checking bench for corr_mac_seq with a sum-of-products
// reference model over a sample history and a coefficient array.
module tb_corr_mac_seq;

  localparam int N     = 20;
  localparam int ACC_W = 25;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic        sample_stb;
  logic [7:0]  rec;
  logic [23:0] thresh;
  logic        coef_we;
  logic [4:0]  coef_addr;
  logic [7:0]  coef_data;
  logic [24:0] corr;
  logic        corr_valid;
  logic        detect;
  logic        busy;
  logic        overrun;

  int n_checks = 0;
  int n_errors = 0;

  int s_tab [20] = '{0, 39, 75, 103, 121, 127, 121, 103, 75, 39,
                     0, -39, -75, -103, -121, -127, -121, -103, -75, -39};
  int hist   [N];
  int coef_m [N];

  corr_mac_seq #(.W(8), .C(8), .N(N), .ACC_W(ACC_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .sample_stb (sample_stb),
    .rec        (rec),
    .thresh     (thresh),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_data  (coef_data),
    .corr       (corr),
    .corr_valid (corr_valid),
    .detect     (detect),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic longint corr_s();
    return longint'($signed(corr));
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      hist[k]   = 0;
      coef_m[k] = s_tab[k % 20];
    end
  endtask

  task automatic model_push(input int r);
    for (int k = N - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = r;
  endtask

  function automatic longint model_corr();
    longint s = 0;
    for (int k = 0; k < N; k++) s += longint'(hist[k]) * longint'(coef_m[k]);
    return s;
  endfunction

  task automatic apply_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic write_coef(input int a, input int d);
    coef_we   = 1'b1;
    coef_addr = 5'(a);
    coef_data = 8'(d);
    step();
    coef_we = 1'b0;
`ifdef CORR_COEF_LOAD_EN
    if (a < N) coef_m[a] = d;
`endif
  endtask

  // One sample transaction: strobe, optional dropped duplicate strobe,
  // optional ena stall, then wait for the result and check it.
  task automatic run_sample(input int r, input int th, input int stall_len, input bit dup);
    longint e;
    longint mag;
    int     cyc;
    rec        = 8'(r);
    thresh     = 24'(th);
    sample_stb = 1'b1;
    step();
    sample_stb = 1'b0;
    model_push(r);
    e   = model_corr();
    mag = (e < 0) ? -e : e;
    check_val("busy_after_stb", longint'(busy), 1);
    cyc = 1;
    while (!corr_valid && cyc < 200) begin
      if (dup && cyc == 1) begin
        sample_stb = 1'b1;
        rec        = 8'($urandom);
      end
      if (stall_len > 0 && cyc == 5) ena = 1'b0;
      if (stall_len > 0 && cyc == 5 + stall_len) ena = 1'b1;
      step();
      sample_stb = 1'b0;
      cyc++;
    end
    ena = 1'b1;
    check_val("latency", longint'(cyc), longint'(N + 2 + stall_len));
    check_val("corr", corr_s(), e);
    check_val("detect", longint'(detect), longint'(mag > longint'(th)));
    check_val("busy_at_valid", longint'(busy), 0);
    $display("sample rec=%0d thresh=%0d corr=%0d detect=%0d latency=%0d",
             r, th, corr_s(), detect, cyc);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_val({tag, "_corr"}, longint'(corr), 0);
    check_val({tag, "_valid"}, longint'(corr_valid), 0);
    check_val({tag, "_detect"}, longint'(detect), 0);
    check_val({tag, "_busy"}, longint'(busy), 0);
    check_val({tag, "_overrun"}, longint'(overrun), 0);
  endtask

  initial begin
    int extra;
    int r;
    int th;
    int st;

    rst        = 1'b1;
    ena        = 1'b1;
    sample_stb = 1'b0;
    rec        = '0;
    thresh     = '0;
    coef_we    = 1'b0;
    coef_addr  = '0;
    coef_data  = '0;
    step();
    step();
    rst = 1'b0;
    model_reset();
    check_outputs_zero("reset");

    // Impulse walks the table out in order.
    run_sample(1, 0, 0, 0);
    for (int j = 1; j < 20; j++) run_sample(0, 0, 0, 0);
    check_val("impulse_last", corr_s(), -39);

    // Matched sine, then a one-tap shift.
    for (int j = 19; j >= 0; j--) run_sample(s_tab[j], 80000, 0, 0);
    check_val("matched_corr", corr_s(), 161842);
    check_val("matched_detect", longint'(detect), 1);
    run_sample(s_tab[19], 80000, 0, 0);

    // DC input against a zero-mean table.
    for (int j = 0; j < 20; j++) run_sample(127, 0, 0, 0);
    check_val("dc_corr", corr_s(), 0);
    check_val("dc_detect", longint'(detect), 0);

    // Randomised samples, thresholds, stalls and back-to-back strobes.
    for (int j = 0; j < 30; j++) begin
      r  = int'($urandom_range(0, 255)) - 128;
      th = int'($urandom_range(0, 60000));
      st = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0;
      run_sample(r, th, st, 0);
      repeat ($urandom_range(0, 3)) step();
    end

    // Dropped strobe sets sticky overrun; only one result appears.
    check_val("overrun_before", longint'(overrun), 0);
    run_sample(77, 0, 0, 1);
    check_val("overrun_set", longint'(overrun), 1);
    extra = 0;
    for (int j = 0; j < 30; j++) begin
      step();
      if (corr_valid) extra++;
    end
    check_val("overrun_single_valid", longint'(extra), 0);
    run_sample(-5, 0, 0, 0);
    check_val("overrun_sticky", longint'(overrun), 1);

    // Five-cycle ena drop mid-MAC stretches the latency to N+7.
    run_sample(55, 1000, 5, 0);

    // Reset mid-MAC: no result, everything cleared, delay line emptied.
    rec        = 8'd100;
    sample_stb = 1'b1;
    step();
    sample_stb = 1'b0;
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_reset();
    extra = 0;
    for (int j = 0; j < 40; j++) begin
      if (corr_valid) extra++;
      step();
    end
    check_val("rst_mid_no_valid", longint'(extra), 0);
    check_outputs_zero("rst_mid");
    run_sample(1, 0, 0, 0);
    check_val("rst_fresh_impulse", corr_s(), 0);

    // Coefficient loading (ignored unless the load feature is built in).
    for (int a = 0; a < N; a++) write_coef(a, -128);
    write_coef(25, 5);
    for (int j = 0; j < 20; j++) run_sample(-128, 0, 0, 0);
`ifdef CORR_COEF_LOAD_EN
    check_val("extreme_neg_corr", corr_s(), 327680);
`endif
    for (int a = 0; a < N; a++) write_coef(a, 127);
    for (int j = 0; j < 20; j++) run_sample(-128, 325119, 0, 0);
`ifdef CORR_COEF_LOAD_EN
    check_val("extreme_pos_corr", corr_s(), -325120);
    check_val("extreme_pos_detect", longint'(detect), 1);
`endif

    // Reset restores the built-in table.
    apply_reset();
    run_sample(1, 0, 0, 0);
    run_sample(0, 0, 0, 0);
    run_sample(0, 0, 0, 0);
    check_val("table_restored", corr_s(), 75);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
